// File: rtl/dense_if.sv
// dense_if: start/done handshake, layer setup, pixel/weight RAM reads and result write port of dense_seq.
interface dense_if #(
  parameter int SIZE   = 11,
  parameter int LANES  = 9,
  parameter int CNT_W  = 9,
  parameter int ADDR_P = 13,
  parameter int ADDR_W = 14
);
  logic                    start;
  logic [CNT_W-1:0]        in_len;
  logic [CNT_W-1:0]        out_len;
  logic                    nozero;
  logic [ADDR_P-1:0]       memstartp;
  logic [ADDR_W-1:0]       memstartw;
  logic [ADDR_P-1:0]       memstartzap;
  logic                    re_p;
  logic [ADDR_P-1:0]       read_addressp;
  logic [LANES*SIZE-1:0]   qp;
  logic                    re_w;
  logic [ADDR_W-1:0]       read_addressw;
  logic [LANES*SIZE-1:0]   qw;
  logic                    we;
  logic [ADDR_P-1:0]       write_addressp;
  logic [SIZE-1:0]         res;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  modport master (
    input  start, in_len, out_len, nozero, memstartp, memstartw, memstartzap, qp, qw,
    output re_p, read_addressp, re_w, read_addressw, we, write_addressp, res, busy, done, ovf
  );
  modport slave (
    output start, in_len, out_len, nozero, memstartp, memstartw, memstartzap, qp, qw,
    input  re_p, read_addressp, re_w, read_addressw, we, write_addressp, res, busy, done, ovf
  );
endinterface

// File: rtl/dense_seq.sv
// dense_seq: sequential dense layer; LANES MACs per beat, rescale/saturate/ReLU, one result write per neuron.
module dense_seq #(
  parameter int SIZE   = 11,
  parameter int LANES  = 9,
  parameter int CNT_W  = 9,
  parameter int ADDR_P = 13,
  parameter int ADDR_W = 14,
  parameter int FRAC   = SIZE - 1,
  parameter int ACC_W  = 2 * SIZE + 8
) (
  input logic      clk,
  input logic      rst,
  dense_if.master  bus
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;
  localparam logic [CNT_W-1:0] LN = CNT_W'(LANES);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  localparam logic [SIZE-1:0] MAXS = SIZE'((64'sd1 <<< (SIZE - 1)) - 64'sd1);
  localparam logic [SIZE-1:0] MINS = ~MAXS;
  state_t state, nxt;
  logic [CNT_W-1:0] len_r, out_r, n, k, rem, m1;
  logic [ADDR_W-1:0] waddr;
  logic nz_r, dc, ovf_r, clip, go, run, wr;
  logic signed [ACC_W-1:0] acc, sum, s, sh;
  logic signed [2*SIZE-1:0] p;
  logic [SIZE-1:0] sat, v;
  assign run = state == RUN;
  assign wr  = state == WRITE;
  assign go  = state == IDLE && bus.start;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = !bus.start ? IDLE : bus.out_len == '0 ? FIN : bus.in_len == '0 ? DRAIN : RUN;
      RUN:     nxt = rem <= LN ? DRAIN : RUN;
      DRAIN:   nxt = dc ? WRITE : DRAIN;
      WRITE:   nxt = n == out_r - 1'b1 ? FIN : len_r == '0 ? DRAIN : RUN;
      default: nxt = IDLE;
    endcase
  end
  // m1 carries the number of live lanes alongside the read data; 0 means bubble.
  always_comb begin
    s = '0;
    p = '0;
    for (int i = 0; i < LANES; i++) begin
      p = $signed(bus.qp[i*SIZE +: SIZE]) * $signed(bus.qw[i*SIZE +: SIZE]);
      s = s + ((CNT_W'(i) < m1) ? ACC_W'(p) : '0);
    end
  end
  always_comb begin
    sh   = acc >>> FRAC;
    clip = sh > MAXV || sh < MINV;
    sat  = sh > MAXV ? MAXS : sh < MINV ? MINS : sh[SIZE-1:0];
    v    = (!nz_r && sat[SIZE-1]) ? '0 : sat;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len_r <= '0;
      out_r <= '0;
      n     <= '0;
      k     <= '0;
      rem   <= '0;
      m1    <= '0;
      waddr <= '0;
      nz_r  <= 1'b0;
      dc    <= 1'b0;
      ovf_r <= 1'b0;
      acc   <= '0;
      sum   <= '0;
    end else begin
      m1  <= run ? (rem <= LN ? rem : LN) : '0;
      sum <= s;
      acc <= wr ? '0 : acc + sum;
      dc  <= state == DRAIN ? ~dc : 1'b0;
      if (go) begin
        len_r <= bus.in_len;
        out_r <= bus.out_len;
        nz_r  <= bus.nozero;
        rem   <= bus.in_len;
        k     <= '0;
        n     <= '0;
        waddr <= bus.memstartw;
        ovf_r <= 1'b0;
      end
      if (run) begin
        k     <= k + 1'b1;
        rem   <= rem - LN;
        waddr <= waddr + 1'b1;
      end
      if (wr) begin
        k     <= '0;
        rem   <= len_r;
        n     <= n + 1'b1;
        ovf_r <= ovf_r | clip;
      end
    end
  assign bus.re_p           = run;
  assign bus.re_w           = run;
  assign bus.read_addressp  = run ? bus.memstartp + ADDR_P'(k) : '0;
  assign bus.read_addressw  = run ? waddr : '0;
  assign bus.we             = wr;
  assign bus.write_addressp = wr ? bus.memstartzap + ADDR_P'(n) : '0;
  assign bus.res            = wr ? v : '0;
  assign bus.busy           = run || state == DRAIN || wr;
  assign bus.done           = state == FIN;
  assign bus.ovf            = ovf_r;
endmodule

// File: tb/tb_dense_seq.sv
// tb_dense_seq: directed scenarios with hand-computed results for dense_seq (SIZE=11, LANES=9, FRAC=10).
module tb_dense_seq;
  localparam int SIZE = 11, LANES = 9, W = SIZE * LANES;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dense_if #(.SIZE(SIZE), .LANES(LANES), .CNT_W(9), .ADDR_P(13), .ADDR_W(14)) bus ();
  dense_seq #(.SIZE(SIZE), .LANES(LANES), .CNT_W(9), .ADDR_P(13), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [W-1:0] mem_p [64];
  logic [W-1:0] mem_w [64];
  always @(posedge clk) begin
    if (bus.re_p) bus.qp <= mem_p[bus.read_addressp[5:0]];
    if (bus.re_w) bus.qw <= mem_w[bus.read_addressw[5:0]];
  end
  int n_cmp = 0, n_bad = 0;
  int nw, dcyc, nre, b1, o1, cnt;
  int wc [8];
  logic [12:0] wa [8];
  logic signed [SIZE-1:0] wd [8];

  function automatic logic [W-1:0] word(input int l0, input int rest);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*SIZE +: SIZE] = SIZE'(i == 0 ? l0 : rest);
    return r;
  endfunction

  // Issues a start and records writes, done cycle and read count; cycle 1 is the one after the start edge.
  task automatic run(input int il, input int ol, input int nz, input int zs, input int ws, input int limit);
    @(negedge clk);
    bus.in_len = 9'(il);
    bus.out_len = 9'(ol);
    bus.nozero = nz[0];
    bus.memstartp = '0;
    bus.memstartw = 14'(ws);
    bus.memstartzap = 13'(zs);
    bus.start = 1'b1;
    nw = 0; dcyc = -1; nre = 0;
    for (int c = 1; c <= limit && dcyc < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 1) begin b1 = int'(bus.busy); o1 = int'(bus.ovf); end
      if (bus.re_p) nre++;
      if (bus.we && nw < 8) begin wa[nw] = bus.write_addressp; wd[nw] = bus.res; wc[nw] = c; nw++; end
      if (bus.done) dcyc = c;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({bus.busy, bus.re_p, bus.re_w, bus.we, bus.done, bus.ovf} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.re_p, bus.re_w, bus.we, bus.done, bus.ovf}); end
    n_cmp++; if (bus.res !== '0 || bus.write_addressp !== '0) begin n_bad++; $display("FAIL reset_data: got res %0d addr %0d want 0 0", bus.res, bus.write_addressp); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_relu();
    mem_p[0] = word(512, 0);
    mem_w[0] = word(512, 512);
    mem_w[1] = word(-512, -512);
    run(9, 2, 0, 100, 0, 30);
    n_cmp++; if (b1 !== 1) begin n_bad++; $display("FAIL relu_busy: got %0d want 1", b1); end
    n_cmp++; if (nw !== 2) begin n_bad++; $display("FAIL relu_nw: got %0d want 2", nw); end
    n_cmp++; if (wa[0] !== 13'd100 || wd[0] !== 256 || wc[0] !== 4) begin n_bad++; $display("FAIL relu_w0: got a%0d d%0d c%0d want a100 d256 c4", wa[0], wd[0], wc[0]); end
    n_cmp++; if (wa[1] !== 13'd101 || wd[1] !== 0 || wc[1] !== 8) begin n_bad++; $display("FAIL relu_w1: got a%0d d%0d c%0d want a101 d0 c8", wa[1], wd[1], wc[1]); end
    n_cmp++; if (dcyc !== 9) begin n_bad++; $display("FAIL relu_done: got %0d want 9", dcyc); end
    n_cmp++; if (nre !== 2) begin n_bad++; $display("FAIL relu_reads: got %0d want 2", nre); end
  endtask

  task automatic test_nozero();
    mem_w[2] = word(-3, -3);
    run(9, 3, 1, 100, 0, 30);
    n_cmp++; if (wd[1] !== -256) begin n_bad++; $display("FAIL nozero_neg: got %0d want -256", wd[1]); end
    n_cmp++; if (wd[2] !== -2) begin n_bad++; $display("FAIL nozero_floor: got %0d want -2", wd[2]); end
    n_cmp++; if (dcyc !== 13 || bus.ovf !== 1'b0) begin n_bad++; $display("FAIL nozero_done_ovf: got %0d/%b want 13/0", dcyc, bus.ovf); end
  endtask

  task automatic test_mask();
    mem_p[0] = word(512, 512);
    mem_w[0] = word(10, 10);
    mem_p[1] = word(512, 1023);
    mem_w[1] = word(100, 1023);
    run(10, 1, 0, 200, 0, 30);
    n_cmp++; if (nw !== 1 || wa[0] !== 13'd200 || wd[0] !== 95) begin n_bad++; $display("FAIL mask_res: got n%0d a%0d d%0d want n1 a200 d95", nw, wa[0], wd[0]); end
    n_cmp++; if (wc[0] !== 5 || dcyc !== 6 || nre !== 2) begin n_bad++; $display("FAIL mask_timing: got c%0d done%0d re%0d want c5 done6 re2", wc[0], dcyc, nre); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2; i++) begin mem_p[i] = word(1023, 1023); mem_w[i] = word(1023, 1023); end
    for (int i = 2; i < 4; i++) mem_w[i] = word(-1024, -1024);
    run(18, 2, 1, 300, 0, 30);
    n_cmp++; if (wd[0] !== 1023) begin n_bad++; $display("FAIL sat_pos: got %0d want 1023", wd[0]); end
    n_cmp++; if (wd[1] !== -1024) begin n_bad++; $display("FAIL sat_neg: got %0d want -1024", wd[1]); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", bus.ovf); end
    run(0, 1, 0, 400, 0, 30);
    n_cmp++; if (o1 !== 0) begin n_bad++; $display("FAIL ovf_clear: got %0d want 0", o1); end
  endtask

  task automatic test_empty();
    run(9, 0, 0, 100, 0, 10);
    n_cmp++; if (dcyc !== 1 || nw !== 0 || nre !== 0) begin n_bad++; $display("FAIL empty: got done%0d w%0d re%0d want done1 w0 re0", dcyc, nw, nre); end
  endtask

  task automatic test_zero_len();
    run(0, 3, 0, 100, 0, 30);
    n_cmp++; if (nw !== 3 || nre !== 0 || dcyc !== 10) begin n_bad++; $display("FAIL zlen_count: got w%0d re%0d done%0d want w3 re0 done10", nw, nre, dcyc); end
    n_cmp++; if (wc[0] !== 3 || wc[1] !== 6 || wc[2] !== 9) begin n_bad++; $display("FAIL zlen_spacing: got %0d %0d %0d want 3 6 9", wc[0], wc[1], wc[2]); end
    n_cmp++; if (wd[0] !== 0 || wd[1] !== 0 || wd[2] !== 0 || wa[2] !== 13'd102) begin n_bad++; $display("FAIL zlen_data: got %0d %0d %0d a%0d want 0 0 0 a102", wd[0], wd[1], wd[2], wa[2]); end
  endtask

  task automatic test_rst_mid();
    mem_p[0] = word(512, 0);
    mem_w[8] = word(100, 100);
    mem_w[9] = word(200, 200);
    mem_w[10] = word(-300, -300);
    mem_w[11] = word(400, 400);
    run(9, 4, 0, 100, 8, 5);
    n_cmp++; if (bus.read_addressw !== 14'd9 || nw !== 1) begin n_bad++; $display("FAIL mid_pre: got addr%0d w%0d want addr9 w1", bus.read_addressw, nw); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.re_p, bus.we, bus.done} !== 4'b0 || bus.read_addressw !== '0) begin n_bad++; $display("FAIL mid_async: got %b addr%0d want 0000 addr0", {bus.busy, bus.re_p, bus.we, bus.done}, bus.read_addressw); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (bus.we) cnt++; end
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL mid_nowe: got %0d want 0", cnt); end
    run(9, 4, 0, 100, 8, 40);
    n_cmp++; if (nw !== 4 || dcyc !== 17) begin n_bad++; $display("FAIL mid_rerun: got w%0d done%0d want w4 done17", nw, dcyc); end
    n_cmp++; if (wd[0] !== 50 || wd[1] !== 100 || wd[2] !== 0 || wd[3] !== 200) begin n_bad++; $display("FAIL mid_data: got %0d %0d %0d %0d want 50 100 0 200", wd[0], wd[1], wd[2], wd[3]); end
    n_cmp++; if (wa[3] !== 13'd103 || wc[3] !== 16) begin n_bad++; $display("FAIL mid_last: got a%0d c%0d want a103 c16", wa[3], wc[3]); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_len = '0;
    bus.out_len = '0;
    bus.nozero = 1'b0;
    bus.memstartp = '0;
    bus.memstartw = '0;
    bus.memstartzap = '0;
    bus.qp = '0;
    bus.qw = '0;
    for (int i = 0; i < 64; i++) begin mem_p[i] = '0; mem_w[i] = '0; end
    test_reset();
    test_relu();
    test_nozero();
    test_mask();
    test_saturate();
    test_empty();
    test_zero_len();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
